// File: rtl/fsub_pipe_if.sv
// Operand/result handshake bundle for fsub_pipe.
// The DUT takes the slave modport; the producer/consumer side takes master.
interface fsub_pipe_if;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] y;
    logic        ovf;
    logic        out_valid;
    logic        out_ready;

    modport slave (
        input  x1, x2, in_valid, out_ready,
        output in_ready, y, ovf, out_valid
    );

    modport master (
        output x1, x2, in_valid, out_ready,
        input  in_ready, y, ovf, out_valid
    );
endinterface

// File: rtl/fsub_pipe.sv
// Three-stage single-precision subtractor y = x1 - x2 (align, subtract/LZC, normalize/pack).
// Macro FSUB_RNE_EN selects round-to-nearest-even; default build truncates.
module fsub_pipe (
    input  logic       clk,
    input  logic       rstn,
    fsub_pipe_if.slave bus
);

    logic        r_v1, r_v2, r_v3;
    logic        w_s1_ld, w_s2_ld, w_s3_ld;

    // Each stage advances when empty or when its successor advances.
    assign w_s3_ld      = !r_v3 || bus.out_ready;
    assign w_s2_ld      = !r_v2 || w_s3_ld;
    assign w_s1_ld      = !r_v1 || w_s2_ld;
    assign bus.in_ready = w_s1_ld;

    // ---------------- S1: align ----------------
    logic [30:0] w_mag_a, w_mag_b, w_mag_l, w_mag_s;
    logic        w_sa, w_sb, w_a_big, w_sign_l, w_sign_s;
    logic [7:0]  w_exp_l, w_exp_s, w_diff;
    logic [4:0]  w_sh;
    logic [23:0] w_sig_l, w_sig_s;
    logic [53:0] w_wide;
    logic [26:0] w_big, w_small;
    logic        w_spec;

    assign w_sa     = bus.x1[31];
    assign w_sb     = ~bus.x2[31];
    assign w_mag_a  = (bus.x1[30:23] == 8'd0) ? 31'd0 : bus.x1[30:0];
    assign w_mag_b  = (bus.x2[30:23] == 8'd0) ? 31'd0 : bus.x2[30:0];
    assign w_a_big  = (w_mag_a >= w_mag_b);
    assign w_mag_l  = w_a_big ? w_mag_a : w_mag_b;
    assign w_mag_s  = w_a_big ? w_mag_b : w_mag_a;
    assign w_sign_l = w_a_big ? w_sa : w_sb;
    assign w_sign_s = w_a_big ? w_sb : w_sa;
    assign w_exp_l  = w_mag_l[30:23];
    assign w_exp_s  = w_mag_s[30:23];
    assign w_sig_l  = (w_exp_l == 8'd0) ? 24'd0 : {1'b1, w_mag_l[22:0]};
    assign w_sig_s  = (w_exp_s == 8'd0) ? 24'd0 : {1'b1, w_mag_s[22:0]};
    assign w_diff   = w_exp_l - w_exp_s;
    assign w_sh     = (w_diff > 8'd27) ? 5'd27 : w_diff[4:0];
    // Low 27 bits of the wide shift catch everything pushed past the field.
    assign w_wide   = {w_sig_s, 3'b000, 27'd0} >> w_sh;
    assign w_small  = {w_wide[53:28], w_wide[27] | (|w_wide[26:0])};
    assign w_big    = {w_sig_l, 3'b000};
    assign w_spec   = (bus.x1[30:23] == 8'hFF) || (bus.x2[30:23] == 8'hFF);

    logic        r1_sign, r1_sub, r1_spec;
    logic [7:0]  r1_exp;
    logic [26:0] r1_big, r1_small;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_v1     <= 1'b0;
            r1_sign  <= 1'b0;
            r1_sub   <= 1'b0;
            r1_spec  <= 1'b0;
            r1_exp   <= 8'd0;
            r1_big   <= 27'd0;
            r1_small <= 27'd0;
        end else if (w_s1_ld) begin
            r_v1 <= bus.in_valid;
            if (bus.in_valid) begin
                r1_sign  <= w_sign_l;
                r1_sub   <= (w_sign_l != w_sign_s);
                r1_spec  <= w_spec;
                r1_exp   <= w_exp_l;
                r1_big   <= w_big;
                r1_small <= w_small;
            end
        end
    end

    // ---------------- S2: add/subtract + LZC ----------------
    logic [27:0] w_sum;
    logic [4:0]  w_lzc;

    assign w_sum = r1_sub ? ({1'b0, r1_big} - {1'b0, r1_small})
                          : ({1'b0, r1_big} + {1'b0, r1_small});

    always_comb begin
        w_lzc = 5'd26;
        for (int i = 1; i <= 26; i++)
            if (w_sum[i]) w_lzc = 5'(26 - i);
    end

    logic        r2_sign, r2_spec;
    logic [7:0]  r2_exp;
    logic [27:0] r2_sum;
    logic [4:0]  r2_lzc;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_v2    <= 1'b0;
            r2_sign <= 1'b0;
            r2_spec <= 1'b0;
            r2_exp  <= 8'd0;
            r2_sum  <= 28'd0;
            r2_lzc  <= 5'd0;
        end else if (w_s2_ld) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r2_sign <= r1_sign;
                r2_spec <= r1_spec;
                r2_exp  <= r1_exp;
                r2_sum  <= w_sum;
                r2_lzc  <= w_lzc;
            end
        end
    end

    // ---------------- S3: normalize, round, pack ----------------
    logic [23:0] w_mant;
    logic        w_inc;
    logic [24:0] w_rnd;
    logic [9:0]  w_e, w_ef;
    logic [22:0] w_frac;
    logic        w_zero;
    logic [31:0] w_y;
    logic        w_ovf;

`ifdef FSUB_RNE_EN
    logic [26:0] w_norm;
    always_comb begin
        if (r2_sum[27]) w_norm = {r2_sum[27:2], r2_sum[1] | r2_sum[0]};
        else            w_norm = r2_sum[26:0] << r2_lzc;
    end
    assign w_mant = w_norm[26:3];
    assign w_inc  = w_norm[2] & (w_norm[3] | w_norm[1] | w_norm[0]);
`else
    assign w_mant = r2_sum[27] ? r2_sum[27:4] : 24'((r2_sum[26:0] << r2_lzc) >> 3);
    assign w_inc  = 1'b0;
`endif

    // 10-bit two's complement exponent covers -26..257.
    assign w_e    = r2_sum[27] ? ({2'b00, r2_exp} + 10'd1) : ({2'b00, r2_exp} - {5'd0, r2_lzc});
    assign w_rnd  = {1'b0, w_mant} + {24'd0, w_inc};
    assign w_ef   = w_e + {9'd0, w_rnd[24]};
    assign w_frac = w_rnd[24] ? 23'd0 : w_rnd[22:0];
    assign w_zero = !(w_rnd[24] | w_rnd[23]);

    always_comb begin
        w_y   = {r2_sign, w_ef[7:0], w_frac};
        w_ovf = 1'b0;
        if (r2_spec) begin
            w_y   = 32'h7FC0_0000;
            w_ovf = 1'b1;
        end else if (w_zero || w_ef[9] || (w_ef == 10'd0)) begin
            w_y = 32'h0000_0000;
        end else if (w_ef >= 10'd255) begin
            w_y   = {r2_sign, 8'hFF, 23'd0};
            w_ovf = 1'b1;
        end
    end

    logic [31:0] r3_y;
    logic        r3_ovf;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_v3   <= 1'b0;
            r3_y   <= 32'd0;
            r3_ovf <= 1'b0;
        end else if (w_s3_ld) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r3_y   <= w_y;
                r3_ovf <= w_ovf;
            end
        end
    end

    assign bus.y         = r3_y;
    assign bus.ovf       = r3_ovf;
    assign bus.out_valid = r_v3;

endmodule
